ssp_uart_master: RTL and testbench
==================================

# ssp_uart_master

Bus-side initiator for the SSP UART register port. It converts single register read/write requests from a host or testbench into one complete SSP frame, driving the SSP select, serial clock, address, command, enable, end-of-cycle and data-in signals. For reads it captures the SSP data-out word and returns it on a one-cycle response strobe. It sits between a host command source and the SSP UART core, and is the stimulus engine for block-level and system-level benches.

## Interface
- CLK_DIV, 4: Clk cycles per SCK half-period; legal values are 1 to 255.
- Clk  input  1  system clock; all logic is on the rising edge.
- Rst  input  1  synchronous, active-low reset.
- req_valid  input  1  host request valid.
- req_ready  output  1  block can accept a request (IDLE only).
- req_addr  input  3  register address.
- req_wnr  input  1  1 = write, 0 = read.
- req_wdata  input  12  write data.
- rsp_valid  output  1  one-cycle pulse at frame completion, for both reads and writes.
- rsp_rdata  output  12  captured SSP_DO; holds its value until the next capture.
- SSP_SSEL  output  1  slave select, active-low.
- SSP_SCK  output  1  serial clock; idles low.
- SSP_RA  output  3  register address.
- SSP_WnR  output  1  command.
- SSP_En  output  1  data-phase enable.
- SSP_EOC  output  1  end of cycle.
- SSP_DI  output  12  data to the slave.
- SSP_DO  input  12  data from the slave.

## Operation
- FSM states: IDLE, SETUP, FRAME, HOLD.
- **IDLE:** req_ready=1. When req_valid=1, the request is latched into frame registers and the FSM moves to SETUP.
- **SETUP:** SSEL=0 for CLK_DIV cycles with SCK low, then the FSM moves to FRAME.
- **FRAME:** 16 bit periods, bit index 0 to 15. Each bit is SCK low for CLK_DIV cycles, then SCK high for CLK_DIV cycles.
  - Bits 0–3 are the header; En=0.
  - Bits 4–15 are the data phase; En=1.
  - EOC=1 for bit 15 only.
- SSP_RA, SSP_WnR and SSP_DI are held constant from SETUP entry to HOLD exit.
  - SSP_DI = req_wdata for writes, 12'h000 for reads.
- rsp_rdata captures SSP_DO on the last Clk cycle of bit 15's high phase. Capture happens for reads only; writes leave rsp_rdata unchanged.
- **HOLD:** SCK low, SSEL=0 and En=EOC=0 for CLK_DIV cycles. Then:
  - SSEL returns to 1.
  - rsp_valid pulses for 1 cycle.
  - The FSM returns to IDLE.
- The half-period counter is 8 bits and the bit counter is 4 bits. The bit counter wraps 15 to 0 only on the exit from FRAME.
- req_valid is ignored outside IDLE; no request queueing.
- **Reset values:**
  - SSP_SSEL=1; SSP_SCK=0; SSP_RA=0; SSP_WnR=0; SSP_En=0; SSP_EOC=0; SSP_DI=0.
  - req_ready=0 during reset, then 1 in IDLE.
  - rsp_valid=0; rsp_rdata=0.
- **Reset mid-frame:** all outputs take their reset values on the next Clk edge, no rsp_valid is issued, and the FSM returns to IDLE.

## Timing
- If a request is accepted on cycle 0:
  - SSEL=0 from cycle 1.
  - The first SCK rise is on cycle 1+2·CLK_DIV.
  - rsp_valid and SSEL=1 are on cycle 1+34·CLK_DIV (137 for CLK_DIV=4).
- rsp_valid and req_ready are both 1 in the completion cycle. A back-to-back request accepted in that cycle drives SSEL=0 on the following cycle, so the minimum SSEL-high gap is 1 cycle.
- Every SCK edge coincides with a Clk edge. SCK has a 50% duty cycle and a period of 2·CLK_DIV Clk cycles.
- When CLK_DIV=1, SCK toggles every Clk cycle.

## Configuration
- SSP_UART_MASTER_IRQ_EN
- **Defined:** adds input IRQ (1 bit) and outputs irq_level and irq_rise (1 bit each).
  - IRQ passes through a 2-flop synchronizer; irq_level is the synchronized value.
  - irq_rise is a one-cycle pulse on each 0→1 transition of irq_level.
  - Both reset to 0.
  - Latency from IRQ to irq_level is 2 cycles; irq_rise coincides with irq_level rising.
- **Undefined:** these ports and the synchronizer flops do not exist; all other behaviour is identical.

## Test plan
- **Write:** CLK_DIV=4, addr=3'h2, wnr=1, wdata=12'hA5C.
  - SSEL low for exactly 136 cycles.
  - 16 SCK rising edges.
  - RA=2, WnR=1, DI=A5C throughout.
  - En high for 96 cycles; EOC high for 8 cycles.
  - rsp_valid on cycle 137.
  - rsp_rdata unchanged.
- **Read:** slave model drives SSP_DO=12'h3F1.
  - DI=0 throughout the frame.
  - rsp_rdata=12'h3F1 when rsp_valid pulses.
- **Back-to-back:** second request asserted in the rsp_valid cycle.
  - Accepted in that same cycle.
  - SSEL high for exactly 1 cycle between frames.
  - req_valid pulses during FRAME are ignored.
- **Reset mid-frame:** Rst=0 at bit 7.
  - All outputs at reset values on the next edge.
  - No rsp_valid.
  - A new request afterwards completes normally.
- **CLK_DIV=1:**
  - SCK toggles every cycle.
  - Frame latency is 35 cycles.
- **With SSP_UART_MASTER_IRQ_EN:** IRQ rises at cycle 10.
  - irq_level=1 at cycle 12.
  - irq_rise is a single pulse at cycle 12.
  - No pulse when IRQ falls.

Source files
------------

// File: rtl/ssp_uart_master.sv
// SSP register-port initiator: turns one host read/write request into a full
// 16-bit SSP frame. Define SSP_UART_MASTER_IRQ_EN to add the synchronized IRQ outputs.
module ssp_uart_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        Clk,
  input  logic        Rst,
`ifdef SSP_UART_MASTER_IRQ_EN
  input  logic        IRQ,
  output logic        irq_level,
  output logic        irq_rise,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_addr,
  input  logic        req_wnr,
  input  logic [11:0] req_wdata,
  output logic        rsp_valid,
  output logic [11:0] rsp_rdata,
  output logic        SSP_SSEL,
  output logic        SSP_SCK,
  output logic [2:0]  SSP_RA,
  output logic        SSP_WnR,
  output logic        SSP_En,
  output logic        SSP_EOC,
  output logic [11:0] SSP_DI,
  input  logic [11:0] SSP_DO
);

  typedef enum logic [1:0] {IDLE, SETUP, FRAME, HOLD} state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  hcnt, hcnt_nxt;
  logic [3:0]  bit_cnt, bit_nxt;
  logic        phase, phase_nxt;
  logic        rsp_nxt, capture;
  logic        half_done;
  logic [2:0]  ra;
  logic        wnr;
  logic [11:0] di;

  assign half_done = (hcnt == HALF_LAST);

  always_ff @(posedge Clk) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // phase: 0 = SCK low half, 1 = SCK high half of the current bit
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    bit_nxt   = bit_cnt;
    phase_nxt = phase;
    rsp_nxt   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = SETUP;
          hcnt_nxt  = '0;
          bit_nxt   = '0;
          phase_nxt = 1'b0;
        end
      end
      SETUP: begin
        if (half_done) begin
          state_nxt = FRAME;
          hcnt_nxt  = '0;
        end else begin
          hcnt_nxt = hcnt + 8'd1;
        end
      end
      FRAME: begin
        if (half_done) begin
          hcnt_nxt  = '0;
          phase_nxt = ~phase;
          if (phase) begin
            bit_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              state_nxt = HOLD;
              capture   = ~wnr;
            end
          end
        end else begin
          hcnt_nxt = hcnt + 8'd1;
        end
      end
      HOLD: begin
        if (half_done) begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
          rsp_nxt   = 1'b1;
        end else begin
          hcnt_nxt = hcnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      hcnt      <= '0;
      bit_cnt   <= '0;
      phase     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ra        <= '0;
      wnr       <= 1'b0;
      di        <= '0;
    end else begin
      hcnt      <= hcnt_nxt;
      bit_cnt   <= bit_nxt;
      phase     <= phase_nxt;
      rsp_valid <= rsp_nxt;
      if (capture) rsp_rdata <= SSP_DO;
      if (state == IDLE && req_valid) begin
        ra  <= req_addr;
        wnr <= req_wnr;
        di  <= req_wnr ? req_wdata : 12'h000;
      end
    end
  end

  assign req_ready = Rst && (state == IDLE);
  assign SSP_SSEL  = (state == IDLE);
  assign SSP_SCK   = (state == FRAME) && phase;
  assign SSP_RA    = ra;
  assign SSP_WnR   = wnr;
  assign SSP_DI    = di;
  assign SSP_En    = (state == FRAME) && (bit_cnt >= 4'd4);
  assign SSP_EOC   = (state == FRAME) && (bit_cnt == 4'd15);

`ifdef SSP_UART_MASTER_IRQ_EN
  logic irq_s1, irq_s2, irq_prev;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      irq_s1   <= 1'b0;
      irq_s2   <= 1'b0;
      irq_prev <= 1'b0;
    end else begin
      irq_s1   <= IRQ;
      irq_s2   <= irq_s1;
      irq_prev <= irq_s2;
    end
  end

  assign irq_level = irq_s2;
  assign irq_rise  = irq_s2 & ~irq_prev;
`endif

endmodule

// File: tb/tb_ssp_uart_master.sv
// Scoreboard bench for ssp_uart_master: frame shape, read capture, back-to-back,
// mid-frame reset, CLK_DIV=1 timing and (when enabled) the IRQ synchronizer.
module tb_ssp_uart_master;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  always #5 Clk = ~Clk;

  logic        req_valid = 1'b0, req_valid1 = 1'b0, req_wnr = 1'b0;
  logic [2:0]  req_addr = '0;
  logic [11:0] req_wdata = '0, slave_word = '0;
  logic        req_ready, rsp_valid, SSP_SSEL, SSP_SCK, SSP_WnR, SSP_En, SSP_EOC;
  logic [11:0] rsp_rdata, SSP_DI, SSP_DO;
  logic [2:0]  SSP_RA;
  logic        req_ready1, rsp_valid1, ssel1, sck1, wnr1, en1, eoc1;
  logic [11:0] rdata1, di1;
  logic [2:0]  ra1;
  logic [11:0] do1 = '0;
`ifdef SSP_UART_MASTER_IRQ_EN
  logic IRQ = 1'b0, irq_level, irq_rise, irq_level1, irq_rise1;
`endif

  // slave returns its word only while EOC is up, so capture timing matters
  assign SSP_DO = SSP_EOC ? slave_word : 12'h000;

  ssp_uart_master #(.CLK_DIV(4)) dut (
    .Clk(Clk), .Rst(Rst),
`ifdef SSP_UART_MASTER_IRQ_EN
    .IRQ(IRQ), .irq_level(irq_level), .irq_rise(irq_rise),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wnr(req_wnr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .SSP_SSEL(SSP_SSEL), .SSP_SCK(SSP_SCK),
    .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR), .SSP_En(SSP_En), .SSP_EOC(SSP_EOC),
    .SSP_DI(SSP_DI), .SSP_DO(SSP_DO)
  );

  ssp_uart_master #(.CLK_DIV(1)) dut1 (
    .Clk(Clk), .Rst(Rst),
`ifdef SSP_UART_MASTER_IRQ_EN
    .IRQ(IRQ), .irq_level(irq_level1), .irq_rise(irq_rise1),
`endif
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr),
    .req_wnr(req_wnr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
    .rsp_rdata(rdata1), .SSP_SSEL(ssel1), .SSP_SCK(sck1),
    .SSP_RA(ra1), .SSP_WnR(wnr1), .SSP_En(en1), .SSP_EOC(eoc1),
    .SSP_DI(di1), .SSP_DO(do1)
  );

  typedef struct {
    logic [2:0]  ra;
    logic        wnr;
    logic [11:0] di;
    logic [11:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_chk = 0, n_err = 0;
  logic [11:0] model_rd = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // per-frame shape counters, checked when the response arrives
  int   ssel_lo = 0, sck_rise = 0, en_hi = 0, eoc_hi = 0, bad = 0;
  logic prev_sck = 1'b0;

  always @(negedge Clk) begin
    if (!Rst) begin
      ssel_lo = 0; sck_rise = 0; en_hi = 0; eoc_hi = 0; bad = 0; prev_sck = 1'b0;
    end else begin
      if (!SSP_SSEL) begin
        ssel_lo++;
        if (SSP_En) en_hi++;
        if (SSP_EOC) eoc_hi++;
        if (q.size() > 0 && {SSP_RA, SSP_WnR, SSP_DI} !== {q[0].ra, q[0].wnr, q[0].di}) bad++;
      end
      if (SSP_SCK && !prev_sck) sck_rise++;
      prev_sck = SSP_SCK;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_cycle", cyc, e.cyc);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("ssel_low_cycles", ssel_lo, 136);
          chk("sck_rises", sck_rise, 16);
          chk("en_cycles", en_hi, 96);
          chk("eoc_cycles", eoc_hi, 8);
          chk("fields_held", bad, 0);
          chk("ssel_at_rsp", SSP_SSEL, 1);
        end
        ssel_lo = 0; sck_rise = 0; en_hi = 0; eoc_hi = 0; bad = 0;
      end
    end
  end

  // called at a negedge; returns at the negedge after the accept cycle
  task automatic do_req(input logic [2:0] a, input logic w, input logic [11:0] d);
    exp_t e;
    chk("req_ready", req_ready, 1);
    req_addr  = a;
    req_wnr   = w;
    req_wdata = d;
    req_valid = 1'b1;
    if (!w) model_rd = slave_word;
    e.ra = a; e.wnr = w; e.di = w ? d : 12'h000; e.rdata = model_rd; e.cyc = cyc + 137;
    q.push_back(e);
    @(negedge Clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 400) begin
      @(negedge Clk);
      n++;
    end
    if (!rsp_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("reset_outputs",
        {SSP_SSEL, SSP_SCK, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI, rsp_valid, rsp_rdata, req_ready},
        {1'b1, 33'd0});
    Rst = 1'b1;
    @(negedge Clk);
    chk("idle_ready", {req_ready, SSP_SSEL}, 2'b11);

    // write, then read, then write that must leave the read value alone
    do_req(3'h2, 1'b1, 12'hA5C);
    wait_rsp("wr1");
    @(negedge Clk);
    slave_word = 12'h3F1;
    do_req(3'h5, 1'b0, 12'hFFF);
    wait_rsp("rd1");
    @(negedge Clk);
    slave_word = 12'h7E2;
    do_req(3'h2, 1'b1, 12'hA5C);
    wait_rsp("wr2");

    // back-to-back read issued in the completion cycle
    do_req(3'h6, 1'b0, 12'h000);
    chk("b2b_ssel_low", SSP_SSEL, 0);
    repeat (20) @(negedge Clk);
    req_addr  = 3'h1;
    req_wnr   = 1'b1;
    req_wdata = 12'h0FF;
    req_valid = 1'b1;
    chk("busy_not_ready", req_ready, 0);
    @(negedge Clk);
    req_valid = 1'b0;
    wait_rsp("b2b");
    repeat (150) @(negedge Clk);

    // reset in the middle of bit 7
    do_req(3'h1, 1'b1, 12'h555);
    repeat (63) @(negedge Clk);
    chk("mid_frame_active", {SSP_SSEL, SSP_En}, 2'b01);
    Rst = 1'b0;
    q.delete();
    model_rd = 12'h000;
    @(negedge Clk);
    chk("mid_reset_outputs",
        {SSP_SSEL, SSP_SCK, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI, rsp_valid, rsp_rdata, req_ready},
        {1'b1, 33'd0});
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    repeat (150) @(negedge Clk);
    slave_word = 12'h0A7;
    do_req(3'h3, 1'b0, 12'h000);
    wait_rsp("post_reset");
    @(negedge Clk);

    // CLK_DIV=1 instance: SCK toggles each cycle, response 35 cycles after accept
    begin
      int   a, tog, rc;
      logic p;
      req_valid1 = 1'b1;
      a = cyc;
      @(negedge Clk);
      req_valid1 = 1'b0;
      p = sck1; tog = 0; rc = -1;
      for (int i = 0; i < 40; i++) begin
        @(negedge Clk);
        if (sck1 !== p) tog++;
        p = sck1;
        if (rsp_valid1 && rc < 0) rc = cyc;
      end
      chk("div1_sck_toggles", tog, 32);
      chk("div1_latency", rc - a, 35);
    end

`ifdef SSP_UART_MASTER_IRQ_EN
    begin
      int pulses = 0;
      IRQ = 1'b1;
      @(negedge Clk);
      chk("irq_lvl_c1", irq_level, 0);
      @(negedge Clk);
      chk("irq_lvl_c2", {irq_level, irq_rise}, 2'b11);
      @(negedge Clk);
      chk("irq_lvl_c3", {irq_level, irq_rise}, 2'b10);
      IRQ = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge Clk);
        if (irq_rise) pulses++;
      end
      chk("irq_fall_no_pulse", {irq_level, 4'(pulses)}, 5'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
